// File: rtl/bit_select_pkg.sv
// Shared constants and FSM state type for the bit_select (select-by-rank) unit.
package bit_select_pkg;

    localparam int W      = 32;
    localparam int BPC    = 4;
    localparam int NCH    = W / BPC;
    localparam int RANK_W = 6;
    localparam int POS_W  = $clog2(W);
    localparam int IDX_W  = $clog2(NCH);

    localparam logic [31:0] SEL_NOT_FOUND = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

endpackage

// File: rtl/bit_select_if.sv
// Request/response bundle for bit_select: start/A/k in, busy/done/found/B out.
interface bit_select_if;
    import bit_select_pkg::*;

    logic              start;
    logic [W-1:0]      A;
    logic [RANK_W-1:0] k;
    logic              busy;
    logic              done;
    logic              found;
    logic [31:0]       B;

    modport master (
        output start, A, k,
        input  busy, done, found, B
    );

    modport slave (
        input  start, A, k,
        output busy, done, found, B
    );

endinterface

// File: rtl/bit_select_chunk_select.sv
// Combinational per-chunk select: popcount of the chunk, whether rank r lands
// inside it, and the LSB-first offset of the r-th set bit.
module bit_select_chunk_select
    import bit_select_pkg::*;
#(
    parameter int CW = BPC
) (
    input  logic [CW-1:0]         chunk_i,
    input  logic [RANK_W-1:0]     rank_i,
    output logic [$clog2(CW):0]   cnt_o,
    output logic                  hit_o,
    output logic [$clog2(CW)-1:0] off_o
);

    localparam int CNT_W = $clog2(CW) + 1;
    localparam int OFF_W = $clog2(CW);

    logic [CNT_W-1:0] run;

    always_comb begin
        run   = '0;
        off_o = '0;
        for (int i = 0; i < CW; i++) begin
            if (chunk_i[i]) begin
                run = run + CNT_W'(1);
                if (RANK_W'(run) == rank_i) begin
                    off_o = OFF_W'(i);
                end
            end
        end
        cnt_o = run;
        hit_o = (rank_i <= RANK_W'(run));
    end

endmodule

// File: rtl/bit_select.sv
// Multi-cycle select unit: bit index of the k-th set bit of A, BPC bits per cycle.
// Optional macro BIT_SELECT_EARLY_EXIT_EN ends the scan right after the hit.
module bit_select
    import bit_select_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    bit_select_if.slave  bus
);

    state_e            state_q;
    logic [W-1:0]      data_q;
    logic [RANK_W-1:0] rem_q;
    logic [IDX_W-1:0]  idx_q;
    logic              hit_q;
    logic [POS_W-1:0]  pos_q;
    logic              busy_q;
    logic              done_q;
    logic              found_q;
    logic [31:0]       b_q;

    logic [BPC-1:0]         chunk;
    logic [$clog2(BPC):0]   cs_cnt;
    logic                   cs_hit;
    logic [$clog2(BPC)-1:0] cs_off;

    logic             hit_d;
    logic [POS_W-1:0] pos_d;
    logic             last_chunk;
    logic             scan_exit;
    logic             k_bad;

    assign chunk = data_q[idx_q*BPC +: BPC];

    bit_select_chunk_select #(
        .CW (BPC)
    ) u_chunk_select (
        .chunk_i (chunk),
        .rank_i  (rem_q),
        .cnt_o   (cs_cnt),
        .hit_o   (cs_hit),
        .off_o   (cs_off)
    );

    // Once a hit is latched the result is frozen for the rest of the scan.
    assign hit_d      = hit_q | cs_hit;
    assign pos_d      = hit_q ? pos_q : {idx_q, cs_off};
    assign last_chunk = (idx_q == IDX_W'(NCH - 1));
    assign k_bad      = (bus.k == '0) || (bus.k > RANK_W'(W));

`ifdef BIT_SELECT_EARLY_EXIT_EN
    assign scan_exit = last_chunk | hit_d;
`else
    assign scan_exit = last_chunk;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            pos_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        data_q  <= bus.A;
                        rem_q   <= bus.k;
                        idx_q   <= '0;
                        hit_q   <= 1'b0;
                        pos_q   <= '0;
                        busy_q  <= 1'b1;
                        found_q <= 1'b0;
                        if (k_bad) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            b_q     <= SEL_NOT_FOUND;
                        end else begin
                            state_q <= SCAN;
                            b_q     <= '0;
                        end
                    end
                end
                SCAN: begin
                    idx_q <= idx_q + IDX_W'(1);
                    hit_q <= hit_d;
                    pos_q <= pos_d;
                    // Subtract only while the target lies beyond this chunk.
                    if (!hit_d) begin
                        rem_q <= rem_q - RANK_W'(cs_cnt);
                    end
                    if (scan_exit) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        found_q <= hit_d;
                        b_q     <= hit_d ? {{(32 - POS_W){1'b0}}, pos_d} : SEL_NOT_FOUND;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.found = found_q;
    assign bus.B     = b_q;

endmodule

// File: tb/tb_bit_select.sv
// Randomized self-checking bench for bit_select against a bit-walking rank model.
module tb_bit_select;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bit_select_if bus();

    bit_select dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Walk the word from the LSB, counting set bits until the k-th one.
    function automatic void ref_sel(input logic [31:0] a, input int kk,
                                    output bit f, output int pos, output int lat);
        int seen;
        seen = 0;
        f    = 1'b0;
        pos  = 0;
        if (kk < 1 || kk > 32) begin
            lat = 1;
            return;
        end
        for (int i = 0; i < 32; i++) begin
            if (!f && a[i]) begin
                seen++;
                if (seen == kk) begin
                    f   = 1'b1;
                    pos = i;
                end
            end
        end
`ifdef BIT_SELECT_EARLY_EXIT_EN
        lat = f ? (pos / 4) + 2 : 9;
`else
        lat = 9;
`endif
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [5:0] kk,
                          input int extra_at, input bit poke_done);
        bit   ef;
        int   epos;
        int   elat;
        int   cyc;
        bit   busy_ok;
        logic [31:0] eb;
        ref_sel(a, int'(kk), ef, epos, elat);
        eb = ef ? 32'(epos) : 32'hFFFF_FFFF;

        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.k     = kk;
        cyc       = 0;
        busy_ok   = 1'b1;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
            if (cyc == 1) bus.start = 1'b0;
            if (extra_at != 0 && cyc == extra_at) begin
                bus.start = 1'b1;
                bus.A     = 32'h0000_0001;
                bus.k     = 6'd1;
            end
            if (extra_at != 0 && cyc == extra_at + 1) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        chk($sformatf("lat A=%h k=%0d", a, kk), 32'(cyc), 32'(elat));
        chk("busy_during_scan", 32'(busy_ok), 32'd1);
        chk("busy_at_done", 32'(bus.busy), 32'd1);
        chk($sformatf("found A=%h k=%0d", a, kk), 32'(bus.found), 32'(ef));
        chk($sformatf("B A=%h k=%0d", a, kk), bus.B, eb);

        if (poke_done) begin
            bus.start = 1'b1;
            bus.A     = $urandom;
            bus.k     = 6'd1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_single_pulse", 32'(bus.done), 32'd0);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("found_hold", 32'(bus.found), 32'(ef));
        chk("B_hold", bus.B, eb);
    endtask

    initial begin
        logic [31:0] ra;
        logic [5:0]  rk;
        bit          ab_ok;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.k     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_found", 32'(bus.found), 32'd0);
        chk("rst_B", bus.B, 32'h0);
        rst = 1'b0;

        run_op(32'h0000_0001, 6'd1, 0, 1'b0);
        run_op(32'h8000_0000, 6'd1, 0, 1'b1);
        run_op(32'hF0F0_F0F0, 6'd5, 0, 1'b0);
        run_op(32'hF0F0_F0F0, 6'd16, 0, 1'b1);
        run_op(32'h0000_00FF, 6'd9, 0, 1'b0);
        run_op(32'h0000_00FF, 6'd0, 0, 1'b1);
        run_op(32'h0000_00FF, 6'd33, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 6'd32, 3, 1'b0);

        // Reset mid-operation aborts it with no done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 32'h0000_0100;
        bus.k     = 6'd1;
        ab_ok     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.done || !bus.busy) ab_ok = 1'b0;
        @(negedge clk);
        if (bus.done) ab_ok = 1'b0;
        @(negedge clk);
        if (bus.done) ab_ok = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_done_before_rst", 32'(ab_ok), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_found", 32'(bus.found), 32'd0);
        chk("abort_B", bus.B, 32'h0);
        rst = 1'b0;
        run_op(32'h0000_0100, 6'd1, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra = ra & $urandom & $urandom;
            rk = 6'($urandom_range(0, 40));
            run_op(ra, rk, ($urandom_range(0, 3) == 0) ? 2 : 0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
